// File: rtl/crc_check_pkg.sv
// Shared types and helpers for the frame-CRC checker: level width and result record.
package crc_check_pkg;

  localparam int CRC_W = 16;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic             ok;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] exp;
  } crc_res_t;

endpackage

// File: rtl/crc_exp_fifo.sv
// Expected-CRC queue: in-order FIFO with first-word-visible head.
// The pointers carry one extra bit so that full and empty can be told apart.
module crc_exp_fifo
  import crc_check_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int LW    = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  localparam int AW = LW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full queue is accepted only when a pop frees the head slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wptr_d  = wptr_q + LW'(do_push);
  assign rptr_d  = rptr_q + LW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/crc_check.sv
// Frame-CRC checker: matches computed CRCs, in order, against queued trailer CRCs,
// and keeps saturating good/bad counters plus sticky overflow/underflow flags.
module crc_check
  import crc_check_pkg::*;
#(
  parameter int CRC_WIDTH  = CRC_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CRC_WIDTH-1:0]         exp_crc,
  input  logic                         exp_vld,
  input  logic [CRC_WIDTH-1:0]         crc_in,
  input  logic                         crc_in_vld,
  input  logic                         clr,
  output logic                         result_vld,
  output logic                         result_ok,
  output logic [CRC_WIDTH-1:0]         result_crc,
  output logic [CRC_WIDTH-1:0]         result_exp,
  output logic [CNT_WIDTH-1:0]         good_cnt,
  output logic [CNT_WIDTH-1:0]         bad_cnt,
  output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                         err_overflow,
  output logic                         err_underflow
);
  logic [CRC_WIDTH-1:0] head;
  logic                 full, empty;
  logic                 pop, bypass, match, ok, ovf, unf;
  logic [CRC_WIDTH-1:0] exp_sel;

  crc_res_t             res_q, res_d;
  logic                 res_vld_q;
  logic [CNT_WIDTH-1:0] good_q, good_d, bad_q, bad_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  // Bypass: empty queue and a same-cycle trailer; match directly, store nothing.
  assign pop     = crc_in_vld && !empty;
  assign bypass  = crc_in_vld && empty && exp_vld;
  assign unf     = crc_in_vld && empty && !exp_vld;
  assign ovf     = exp_vld && full && !pop;
  assign match   = pop || bypass;
  assign exp_sel = bypass ? exp_crc : head;
  assign ok      = (crc_in == exp_sel);

  crc_exp_fifo #(.DEPTH(FIFO_DEPTH), .W(CRC_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (exp_vld && !bypass),
    .data_i  (exp_crc),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    res_d  = match ? '{ok: ok, crc: crc_in, exp: exp_sel} : res_q;
    good_d = good_q;
    bad_d  = bad_q;
    ovf_d  = ovf_q | ovf;
    unf_d  = unf_q | unf;
    if (match && ok && good_q != '1)  good_d = good_q + 1'b1;
    if (match && !ok && bad_q != '1)  bad_d  = bad_q + 1'b1;
    // Clear wins over any same-cycle count or flag event.
    if (clr) begin
      good_d = '0;
      bad_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      res_q     <= res_d;
      res_vld_q <= match;
      good_q    <= good_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign result_vld    = res_vld_q;
  assign result_ok     = res_q.ok;
  assign result_crc    = res_q.crc;
  assign result_exp    = res_q.exp;
  assign good_cnt      = good_q;
  assign bad_cnt       = bad_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check with CNT_WIDTH=4 so counter saturation is reachable.
module tb_crc_check;
  localparam int CW = 16;
  localparam int D  = 8;
  localparam int NW = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] exp_crc, crc_in;
  logic          exp_vld, crc_in_vld, clr;
  logic          result_vld, result_ok;
  logic [CW-1:0] result_crc, result_exp;
  logic [NW-1:0] good_cnt, bad_cnt;
  logic [LW-1:0] fifo_level;
  logic          err_overflow, err_underflow;

  int checks = 0;
  int failures = 0;

  crc_check #(.CRC_WIDTH(CW), .FIFO_DEPTH(D), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_crc(exp_crc), .exp_vld(exp_vld),
    .crc_in(crc_in), .crc_in_vld(crc_in_vld), .clr(clr),
    .result_vld(result_vld), .result_ok(result_ok),
    .result_crc(result_crc), .result_exp(result_exp),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .fifo_level(fifo_level),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Apply the currently driven inputs for one edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exp_vld = 0; crc_in_vld = 0; clr = 0;
  endtask

  logic [CW-1:0] pushed [3] = '{16'h1234, 16'hABCD, 16'h0F0F};
  logic [CW-1:0] got    [3] = '{16'h1234, 16'hABCD, 16'h0000};
  logic          okv    [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 0; exp_crc = '0; crc_in = '0; idle();
    #1;
    chk("rst_vld", result_vld, 0);
    chk("rst_good", good_cnt, 0);
    chk("rst_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();

    // Three in-order frames, last one corrupted.
    for (int i = 0; i < 3; i++) begin
      exp_vld = 1; exp_crc = pushed[i]; step();
    end
    idle();
    chk("t1_level3", fifo_level, 3);
    for (int i = 0; i < 3; i++) begin
      crc_in_vld = 1; crc_in = got[i]; step();
      chk($sformatf("t1_vld%0d", i), result_vld, 1);
      chk($sformatf("t1_ok%0d", i), result_ok, okv[i]);
      chk($sformatf("t1_exp%0d", i), result_exp, pushed[i]);
      chk($sformatf("t1_crc%0d", i), result_crc, got[i]);
    end
    idle(); step();
    chk("t1_vld_off", result_vld, 0);
    chk("t1_good", good_cnt, 2);
    chk("t1_bad", bad_cnt, 1);
    chk("t1_level0", fifo_level, 0);

    // Bypass on empty queue.
    clr = 1; step(); idle();
    exp_vld = 1; exp_crc = 16'h5A5A; crc_in_vld = 1; crc_in = 16'h5A5A; step(); idle();
    chk("byp_vld", result_vld, 1);
    chk("byp_ok", result_ok, 1);
    chk("byp_level", fifo_level, 0);
    chk("byp_unf", err_underflow, 0);
    chk("byp_good", good_cnt, 1);

    // Overflow: nine pushes into an eight-deep queue.
    clr = 1; step(); idle();
    for (int i = 0; i < 9; i++) begin
      exp_vld = 1; exp_crc = CW'(16'h1000 + i); step();
      if (i == 7) begin
        chk("ovf_pre", err_overflow, 0);
        chk("ovf_full", fifo_level, 8);
      end
    end
    idle();
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_level", fifo_level, 8);
    clr = 1; step(); idle();
    chk("ovf_clr", err_overflow, 0);
    exp_vld = 1; exp_crc = 16'h2000; crc_in_vld = 1; crc_in = 16'h1000; step(); idle();
    chk("pp_level", fifo_level, 8);
    chk("pp_ovf", err_overflow, 0);
    chk("pp_ok", result_ok, 1);
    for (int i = 1; i < 9; i++) begin
      crc_in_vld = 1; crc_in = 16'hFFFF; step();
      chk($sformatf("drain_exp%0d", i), result_exp, (i < 8) ? 32'(16'h1000 + i) : 32'h2000);
    end
    idle(); step();
    chk("drain_level", fifo_level, 0);
    chk("drain_bad", bad_cnt, 8);

    // Underflow then clear.
    clr = 1; step(); idle();
    crc_in_vld = 1; crc_in = 16'h1111; step(); idle();
    chk("unf_flag", err_underflow, 1);
    chk("unf_vld", result_vld, 0);
    chk("unf_good", good_cnt, 0);
    chk("unf_bad", bad_cnt, 0);
    clr = 1; step(); idle();
    chk("unf_clr", err_underflow, 0);

    // Saturation at 4 bits, then clear racing a passing result.
    for (int i = 0; i < 17; i++) begin
      exp_vld = 1; exp_crc = CW'(i * 3); crc_in_vld = 1; crc_in = CW'(i * 3); step();
    end
    idle();
    chk("sat_good", good_cnt, 15);
    exp_vld = 1; exp_crc = 16'h7777; crc_in_vld = 1; crc_in = 16'h7777; clr = 1; step(); idle();
    chk("race_vld", result_vld, 1);
    chk("race_good", good_cnt, 0);

    // Async reset with entries queued.
    for (int i = 0; i < 3; i++) begin
      exp_vld = 1; exp_crc = pushed[i]; step();
    end
    idle();
    chk("ar_pre_level", fifo_level, 3);
    #2 rst_n = 0; #1;
    chk("ar_level", fifo_level, 0);
    chk("ar_vld", result_vld, 0);
    chk("ar_ok", result_ok, 0);
    chk("ar_exp", result_exp, 0);
    @(negedge clk); rst_n = 1;
    step();
    chk("ar_novld", result_vld, 0);
    crc_in_vld = 1; crc_in = 16'h1234; step(); idle();
    chk("ar_unf", err_underflow, 1);
    chk("ar_stale", result_vld, 0);
    chk("ar_good", good_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
